// File: rtl/dadda_sweep_if.sv
// Bundle between the sweep controller and its host / multiplier under test.
// The host side (master) requests sweeps and returns products; the controller side (slave) drives operands and reports.
interface dadda_sweep_if #(
  parameter int N = 8
);
  logic             start;
  logic             abort;
  logic [N-1:0]     mul_a;
  logic [N-1:0]     mul_b;
  logic [2*N-1:0]   mul_p;
  logic             busy;
  logic             done;
  logic [2*N:0]     err_count;
  logic [2*N-1:0]   max_ed;
  logic [4*N-1:0]   sum_ed;

  modport master (
    output start, abort, mul_p,
    input  mul_a, mul_b, busy, done, err_count, max_ed, sum_ed
  );

  modport slave (
    input  start, abort, mul_p,
    output mul_a, mul_b, busy, done, err_count, max_ed, sum_ed
  );
endinterface

// File: rtl/dadda_sweep_ctrl.sv
// Exhaustive error-characterisation sweep for an approximate NxN multiplier:
// visits every (a,b) pair, waits MUL_LAT cycles, accumulates error statistics.
//
// state  | meaning
// IDLE   | results of last sweep held, waiting for start
// WAIT   | operands stable, letting the multiplier settle for MUL_LAT+1 cycles
// ACC    | compare returned product against exact one, step to next pair
// DONE   | one-cycle completion pulse
module dadda_sweep_ctrl #(
  parameter int N       = 8,
  parameter int MUL_LAT = 0
) (
  input  logic         clk,
  input  logic         rst,
  dadda_sweep_if.slave bus
);

  localparam int             CW    = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;
  localparam logic [CW-1:0]  LAT_C = CW'(MUL_LAT);
  localparam logic [N-1:0]   OP_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACC, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*N:0]     err_q, err_d;
  logic [2*N-1:0]   max_q, max_d;
  logic [4*N-1:0]   sum_q, sum_d;

  logic [2*N-1:0]   exact;
  logic [2*N-1:0]   ed;
  logic             last_pair;
  logic             busy, done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      max_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      max_q   <= max_d;
      sum_q   <= sum_d;
    end
  end

  assign last_pair = (a_q == OP_MAX) && (b_q == OP_MAX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_WAIT;
      S_WAIT: begin
        if (bus.abort)           state_d = S_DONE;
        else if (cnt_q == LAT_C) state_d = S_ACC;
      end
      S_ACC: begin
        if (bus.abort || last_pair) state_d = S_DONE;
        else                        state_d = S_WAIT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_WAIT, S_ACC: busy = 1'b1;
      S_DONE:        done = 1'b1;
      default:       ;
    endcase
  end

  // Error distance is taken at full product width without wrap-around.
  always_comb begin
    exact = {{N{1'b0}}, a_q} * {{N{1'b0}}, b_q};
    ed    = (exact >= bus.mul_p) ? (exact - bus.mul_p) : (bus.mul_p - exact);
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    err_d = err_q;
    max_d = max_q;
    sum_d = sum_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d   = '0;
          b_d   = '0;
          cnt_d = '0;
          err_d = '0;
          max_d = '0;
          sum_d = '0;
        end
      end
      S_WAIT: begin
        if (!bus.abort) cnt_d = cnt_q + 1'b1;
      end
      S_ACC: begin
        if (!bus.abort) begin
          err_d = err_q + {{(2*N){1'b0}}, (ed != '0)};
          max_d = (ed > max_q) ? ed : max_q;
          sum_d = sum_q + {{(2*N){1'b0}}, ed};
          if (!last_pair) begin
            a_d   = a_q + 1'b1;
            cnt_d = '0;
            if (a_q == OP_MAX) b_d = b_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.mul_a     = a_q;
  assign bus.mul_b     = b_q;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.err_count = err_q;
  assign bus.max_ed    = max_q;
  assign bus.sum_ed    = sum_q;

endmodule

// File: tb/tb_dadda_sweep_ctrl.sv
// Bench for dadda_sweep_ctrl: two N=2 instances (MUL_LAT 0 and 2), table-driven sweeps,
// randomized error tables against an arithmetic model, and abort / reset corner sequences.
module tb_dadda_sweep_ctrl;
  localparam int N  = 2;
  localparam int NP = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dadda_sweep_if #(.N(N)) if0 ();
  dadda_sweep_if #(.N(N)) if1 ();

  dadda_sweep_ctrl #(.N(N), .MUL_LAT(0)) u_lat0 (.clk(clk), .rst(rst), .bus(if0.slave));
  dadda_sweep_ctrl #(.N(N), .MUL_LAT(2)) u_lat2 (.clk(clk), .rst(rst), .bus(if1.slave));

  int         n_cmp = 0;
  int         n_bad = 0;
  int         sel   = 0;
  int         mode_v = 0;
  logic       start_r = 1'b0;
  logic       abort_r = 1'b0;
  logic [3:0] rnd_tab [NP];

  // Multiplier under test: mode 0 exact, 1 LSB cleared, 2 stuck at zero, 3 random table.
  function automatic logic [3:0] mul_fn(input int md, input int a, input int b);
    int ex;
    ex = a * b;
    case (md)
      0:       return 4'(ex);
      1:       return 4'(ex & ~1);
      2:       return 4'd0;
      default: return rnd_tab[b*4 + a];
    endcase
  endfunction

  assign if0.start = (sel == 0) && start_r;
  assign if1.start = (sel == 1) && start_r;
  assign if0.abort = (sel == 0) && abort_r;
  assign if1.abort = (sel == 1) && abort_r;
  assign if0.mul_p = mul_fn(mode_v, int'(if0.mul_a), int'(if0.mul_b));

  // Two-cycle-latency multiplier for the MUL_LAT=2 instance.
  logic [3:0] p1_s1, p1_s2;
  always @(posedge clk) begin
    p1_s1 <= mul_fn(mode_v, int'(if1.mul_a), int'(if1.mul_b));
    p1_s2 <= p1_s1;
  end
  assign if1.mul_p = p1_s2;

  logic [1:0] oa, ob;
  logic       obusy, odone;
  logic [4:0] oerr;
  logic [3:0] omax;
  logic [7:0] osum;
  assign oa    = sel ? if1.mul_a     : if0.mul_a;
  assign ob    = sel ? if1.mul_b     : if0.mul_b;
  assign obusy = sel ? if1.busy      : if0.busy;
  assign odone = sel ? if1.done      : if0.done;
  assign oerr  = sel ? if1.err_count : if0.err_count;
  assign omax  = sel ? if1.max_ed    : if0.max_ed;
  assign osum  = sel ? if1.sum_ed    : if0.sum_ed;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model(input int md, input int np, output longint e, output longint m, output longint s);
    e = 0; m = 0; s = 0;
    for (int i = 0; i < np; i++) begin
      int a, b, ex, p, d;
      a  = i % 4;
      b  = i / 4;
      ex = a * b;
      p  = int'(mul_fn(md, a, b));
      d  = (ex > p) ? ex - p : p - ex;
      if (d != 0) e++;
      if (d > m)  m = d;
      s += d;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " err"},  oerr,  0);
    chk({tag, " max"},  omax,  0);
    chk({tag, " sum"},  osum,  0);
    chk({tag, " a"},    oa,    0);
    chk({tag, " b"},    ob,    0);
    chk({tag, " busy"}, obusy, 0);
    chk({tag, " done"}, odone, 0);
  endtask

  // Full sweep on instance s; checks start clearing, ordering, operand stability, busy and done width.
  task automatic run_sweep(input int s, input int md, input bit with_abort, input bit mid_start,
                           output int cyc);
    int  lat, prev, run, order_bad, run_bad, busy_bad, idx;
    bit  seen;
    sel = s; mode_v = md;
    lat = s ? 2 : 0;
    @(negedge clk);
    start_r = 1'b1; abort_r = with_abort;
    cyc = 0; seen = 0; prev = 0; run = 0; order_bad = 0; run_bad = 0; busy_bad = 0;
    while (cyc < 1000 && !seen) begin
      @(negedge clk);
      cyc++;
      idx = int'(ob) * 4 + int'(oa);
      if (cyc == 1) begin
        start_r = 1'b0; abort_r = 1'b0;
        chk("start clears", {oerr, omax, osum, oa, ob}, 0);
      end
      if (mid_start) start_r = (cyc == 7);
      if (odone) seen = 1;
      else begin
        if (!obusy) busy_bad++;
        if (cyc == 1) begin
          prev = idx; run = 1;
        end else if (idx == prev) run++;
        else begin
          if (run != lat + 2)  run_bad++;
          if (idx != prev + 1) order_bad++;
          prev = idx; run = 1;
        end
      end
    end
    start_r = 1'b0;
    chk("done seen", seen, 1);
    chk("busy during sweep", busy_bad, 0);
    chk("pair order", order_bad, 0);
    chk("operand hold cycles", run_bad, 0);
    chk("last pair hold", run, lat + 2);
    chk("last pair index", prev, NP - 1);
    chk("busy in done", obusy, 0);
    @(negedge clk);
    chk("done one cycle", odone, 0);
  endtask

  typedef struct {
    int     s;
    int     md;
    bit     wa;
    bit     mid;
    longint e_err;
    longint e_max;
    longint e_sum;
    int     e_cyc;
  } vec_t;

  vec_t   tab [6];
  int     cyc;
  longint me, mm, ms;
  int     dcount;

  initial begin
    tab[0] = '{0, 0, 1'b0, 1'b0, 0, 0, 0,  33};
    tab[1] = '{0, 1, 1'b0, 1'b0, 4, 1, 4,  33};
    tab[2] = '{1, 2, 1'b0, 1'b0, 9, 9, 36, 65};
    tab[3] = '{1, 0, 1'b0, 1'b1, 0, 0, 0,  65};
    tab[4] = '{0, 2, 1'b1, 1'b0, 9, 9, 36, 33};
    tab[5] = '{1, 1, 1'b0, 1'b1, 4, 1, 4,  65};
    for (int i = 0; i < NP; i++) rnd_tab[i] = 4'd0;

    rst = 1'b1;
    #12;
    for (int s = 0; s < 2; s++) begin
      sel = s; #1;
      check_all_zero("reset");
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_sweep(tab[i].s, tab[i].md, tab[i].wa, tab[i].mid, cyc);
      chk($sformatf("vec%0d cycles", i), cyc,  tab[i].e_cyc);
      chk($sformatf("vec%0d err", i),    oerr, tab[i].e_err);
      chk($sformatf("vec%0d max", i),    omax, tab[i].e_max);
      chk($sformatf("vec%0d sum", i),    osum, tab[i].e_sum);
    end

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NP; i++) begin
        if ($urandom_range(0, 1) == 1) rnd_tab[i] = 4'((i % 4) * (i / 4));
        else                           rnd_tab[i] = 4'($urandom_range(0, 15));
      end
      model(3, NP, me, mm, ms);
      run_sweep(r % 2, 3, 1'b0, 1'b0, cyc);
      chk($sformatf("rnd%0d cycles", r), cyc, (r % 2) ? 65 : 33);
      chk($sformatf("rnd%0d err", r), oerr, me);
      chk($sformatf("rnd%0d max", r), omax, mm);
      chk($sformatf("rnd%0d sum", r), osum, ms);
    end

    // Abort while pair (1,2) is in flight on the MUL_LAT=0 instance.
    sel = 0; mode_v = 2;
    @(negedge clk); start_r = 1'b1;
    @(negedge clk); start_r = 1'b0;
    cyc = 0;
    while (cyc < 200 && !(oa == 2'd1 && ob == 2'd2)) begin
      @(negedge clk); cyc++;
    end
    chk("abort target reached", (oa == 2'd1 && ob == 2'd2), 1);
    abort_r = 1'b1;
    dcount = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      abort_r = 1'b0;
      if (odone) dcount++;
    end
    model(2, 9, me, mm, ms);
    chk("abort done pulses", dcount, 1);
    chk("abort err", oerr, me);
    chk("abort max", omax, mm);
    chk("abort sum", osum, ms);
    chk("abort a hold", oa, 1);
    chk("abort b hold", ob, 2);
    chk("abort busy", obusy, 0);
    run_sweep(0, 2, 1'b0, 1'b0, cyc);
    chk("after abort cycles", cyc, 33);
    chk("after abort err", oerr, 9);
    chk("after abort sum", osum, 36);

    // Reset during WAIT at pair (3,1) on the MUL_LAT=2 instance.
    sel = 1; mode_v = 2;
    @(negedge clk); start_r = 1'b1;
    @(negedge clk); start_r = 1'b0;
    cyc = 0;
    while (cyc < 200 && !(oa == 2'd3 && ob == 2'd1)) begin
      @(negedge clk); cyc++;
    end
    chk("reset target reached", (oa == 2'd3 && ob == 2'd1), 1);
    chk("reset target busy", obusy, 1);
    #1 rst = 1'b1;
    #1 check_all_zero("midsweep reset");
    #1 rst = 1'b0;
    run_sweep(1, 2, 1'b0, 1'b0, cyc);
    chk("after reset cycles", cyc, 65);
    chk("after reset err", oerr, 9);
    chk("after reset max", omax, 9);
    chk("after reset sum", osum, 36);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dadda_sweep_ctrl.md
Name: dadda_sweep_ctrl

Overview:
Hardware sweep controller for the approximate N×N Dadda multiplier. It walks every operand pair (A,B) in order, drives the external multiplier, waits a configurable latency, and compares the returned product against an internal exact product. It accumulates error count, maximum error distance and sum of error distances, and is the on-chip counterpart of the exhaustive error-characterisation flow used for the multiplier library.

Parameters:
N, 8, operand width; product width is 2N.
MUL_LAT, 0, clock cycles after operands change before mul_p is valid (0 = combinational multiplier).

Ports:
clk  input  1  single system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  one-cycle request to begin a sweep; ignored unless state is IDLE.
abort  input  1  terminates a running sweep; accumulators hold their current values.
mul_a  output  N  operand A to multiplier under test.
mul_b  output  N  operand B to multiplier under test.
mul_p  input  2N  product returned by multiplier under test.
busy  output  1  high in WAIT and ACC states.
done  output  1  one-cycle pulse when a sweep completes or is aborted.
err_count  output  2N+1  number of pairs with mul_p != exact.
max_ed  output  2N  maximum |exact - mul_p| seen.
sum_ed  output  4N  sum of |exact - mul_p| over all pairs swept.

Behaviour:
- Reset (async, immediate): state=IDLE; mul_a, mul_b, err_count, max_ed, sum_ed, done, busy = 0. Reset mid-sweep discards all progress.
- States: IDLE, WAIT, ACC, DONE.
- IDLE: start=1 -> clear err_count/max_ed/sum_ed, mul_a=mul_b=0, wait counter=0, go WAIT. Results of the previous sweep stay visible until the next start.
- WAIT: lasts MUL_LAT+1 cycles. Counter increments each cycle; at counter==MUL_LAT go ACC. Operands are stable throughout.
- ACC, one cycle:
  - exact = mul_a*mul_b at full 2N width; ed = |exact - mul_p| at 2N width, no wrap.
  - err_count += (ed!=0); max_ed = max(max_ed, ed); sum_ed += ed zero-extended to 4N. No overflow is possible: at most 2^(2N) pairs × (2^(2N)-1).
  - If mul_a==2^N-1 and mul_b==2^N-1, go DONE.
  - Otherwise mul_a increments (inner loop). When mul_a wraps to 0, mul_b increments. Counter clears and state returns to WAIT.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in DONE.
- abort: sampled in WAIT/ACC and overrides ACC accumulation in the same cycle. Go DONE; mul_a/mul_b hold.
- Ordering: pair (a,b) is visited at index b·2^N + a. Cycles per pair = MUL_LAT+2. Time from start to done = 2^(2N)·(MUL_LAT+2)+1 cycles.
- start while busy: ignored. start and abort together in IDLE: abort ignored, sweep starts.
- Outputs are registered and change only on clk edges or reset.

Test Plan:
- N=2, MUL_LAT=0, mul_p = exact product -> done 33 cycles after start; err_count=0, max_ed=0, sum_ed=0.
- N=2, MUL_LAT=0, mul_p = exact with LSB cleared -> err_count=4, max_ed=1, sum_ed=4.
- N=2, MUL_LAT=2, mul_p tied to 0 -> err_count=9, max_ed=9, sum_ed=36, done at cycle 65; mul_a/mul_b stable for 4 cycles per pair.
- N=8, MUL_LAT=0, exact multiplier -> err_count=0 after 131073 cycles; then with mul_p stuck at 0 -> err_count=65025, max_ed=65025, sum_ed=1065369600.
- N=2, assert abort during pair (1,2), then start again -> one done pulse; counts cover only pairs before (1,2); the new sweep clears them and restarts from (0,0).
- Assert rst during WAIT at pair (3,1) -> all outputs 0 immediately, state IDLE; the next start sweeps from (0,0) with correct totals.
